kd_tree_ctrl: RTL and testbench

- Synthesizable sequencer that drives the root node of the kd-tree node network over its command/data link.
- Runs the full build sequence: tree reset, center fill from a ready/valid stream, sort start, and wait for sort completion.
- Generalised in data width, center count and timeout; adds per-phase timeouts, error reporting and restart on demand.
- Sits between the pixel/center source and the root node.

---
 rtl/kd_tree_ctrl_if.sv | 24 ++
 rtl/kd_tree_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_kd_tree_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/kd_tree_ctrl_if.sv
// kd_tree_ctrl_if: center stream and root-node command/data link of the kd-tree build sequencer.
interface kd_tree_ctrl_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned CMD_W  = 5
);
  logic              center_valid;
  logic              center_ready;
  logic [DATA_W-1:0] center_data;
  logic [CMD_W-1:0]  cmd_to_root;
  logic [DATA_W-1:0] data_to_root;
  logic [CMD_W-1:0]  cmd_from_root;

  // Controller side
  modport master (
    input  center_valid, center_data, cmd_from_root,
    output center_ready, cmd_to_root, data_to_root
  );

  // Center source / root node side
  modport slave (
    output center_valid, center_data, cmd_from_root,
    input  center_ready, cmd_to_root, data_to_root
  );
endinterface

// File: rtl/kd_tree_ctrl.sv
// kd_tree_ctrl: drives the kd-tree root node through reset, center fill,
// sort start and sort completion, with per-phase timeouts and error codes.
// Optional macro KD_TREE_CTRL_PERF_EN adds a sort-latency counter on sort_cycles.
module kd_tree_ctrl #(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned CMD_W       = 5,
  parameter int unsigned NUM_CENTERS = 20,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  kd_tree_ctrl_if.master bus,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [31:0] sort_cycles
);

  localparam int unsigned TCNT_W = $clog2(TIMEOUT);
  localparam int unsigned FCNT_W = 16;

  localparam logic [CMD_W-1:0] CMD_NOP       = CMD_W'(5'h00);
  localparam logic [CMD_W-1:0] CMD_RST       = CMD_W'(5'h1f);
  localparam logic [CMD_W-1:0] CMD_RST_DONE  = CMD_W'(5'h1e);
  localparam logic [CMD_W-1:0] CMD_FILL      = CMD_W'(5'h01);
  localparam logic [CMD_W-1:0] CMD_FILL_DONE = CMD_W'(5'h05);
  localparam logic [CMD_W-1:0] CMD_SORT      = CMD_W'(5'h09);
  localparam logic [CMD_W-1:0] CMD_SORT_OK   = CMD_W'(5'h0f);

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [FCNT_W-1:0] FCNT_MAX  = FCNT_W'(NUM_CENTERS);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_FILL, S_SORT_GO, S_SORT_WAIT, S_DONE, S_ERR
  } state_t;

  state_t            state;
  logic [TCNT_W-1:0] tcnt;
  logic [FCNT_W-1:0] fill_cnt;

  logic rst_done, fill_done, sort_ok, tmo, accept;

  assign rst_done  = (bus.cmd_from_root == CMD_RST_DONE);
  assign fill_done = (bus.cmd_from_root == CMD_FILL_DONE);
  assign sort_ok   = (bus.cmd_from_root == CMD_SORT_OK);
  assign tmo       = (tcnt == TCNT_LAST);

  // Ready only in FILL, below the center quota, and never when the root signals fill done
  assign bus.center_ready = (state == S_FILL) && (fill_cnt < FCNT_MAX) && !fill_done;
  assign accept           = bus.center_valid && bus.center_ready;

  // Sequencer state, registered outputs and phase counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      tcnt             <= '0;
      fill_cnt         <= '0;
      bus.cmd_to_root  <= CMD_NOP;
      bus.data_to_root <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      err_code         <= 2'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          bus.cmd_to_root <= CMD_NOP;
          if (start) begin
            state           <= S_RST;
            bus.cmd_to_root <= CMD_RST;
            busy            <= 1'b1;
            done            <= 1'b0;
            error           <= 1'b0;
            err_code        <= 2'd0;
            fill_cnt        <= '0;
            tcnt            <= '0;
          end
        end
        S_RST: begin
          if (rst_done) begin
            state           <= S_FILL;
            bus.cmd_to_root <= CMD_NOP;
            tcnt            <= '0;
          end else if (tmo) begin
            state           <= S_ERR;
            bus.cmd_to_root <= CMD_NOP;
            busy            <= 1'b0;
            error           <= 1'b1;
            err_code        <= 2'd1;
            tcnt            <= '0;
          end else begin
            bus.cmd_to_root <= CMD_RST;
            tcnt            <= tcnt + TCNT_W'(1);
          end
        end
        S_FILL: begin
          if (fill_done) begin
            state            <= S_SORT_GO;
            bus.cmd_to_root  <= CMD_SORT;
            bus.data_to_root <= '0;
            tcnt             <= '0;
          end else if (accept) begin
            bus.cmd_to_root  <= CMD_FILL;
            bus.data_to_root <= bus.center_data;
            fill_cnt         <= fill_cnt + FCNT_W'(1);
            tcnt             <= '0;
          end else if (tmo) begin
            state           <= S_ERR;
            bus.cmd_to_root <= CMD_NOP;
            busy            <= 1'b0;
            error           <= 1'b1;
            err_code        <= 2'd2;
            tcnt            <= '0;
          end else begin
            bus.cmd_to_root <= CMD_NOP;
            tcnt            <= tcnt + TCNT_W'(1);
          end
        end
        S_SORT_GO: begin
          bus.cmd_to_root <= CMD_NOP;
          tcnt            <= '0;
          if (sort_ok) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= S_SORT_WAIT;
          end
        end
        S_SORT_WAIT: begin
          bus.cmd_to_root <= CMD_NOP;
          if (sort_ok) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            tcnt  <= '0;
          end else if (tmo) begin
            state    <= S_ERR;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= 2'd3;
            tcnt     <= '0;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        default: begin
          state           <= S_IDLE;
          bus.cmd_to_root <= CMD_NOP;
          busy            <= 1'b0;
        end
      endcase
    end
  end

`ifdef KD_TREE_CTRL_PERF_EN
  logic [31:0] perf_cnt;
  logic        in_sort;

  assign in_sort = (state == S_SORT_GO) || (state == S_SORT_WAIT);

  // Sort latency: cycles from the start_sorting command to valid_sort, saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cnt    <= '0;
      sort_cycles <= '0;
    end else begin
      if ((state == S_FILL) && fill_done) begin
        perf_cnt <= '0;
      end else if (in_sort && !sort_ok && (perf_cnt != 32'hFFFF_FFFF)) begin
        perf_cnt <= perf_cnt + 32'd1;
      end
      if (in_sort && sort_ok) begin
        sort_cycles <= perf_cnt;
      end else if (((state == S_IDLE) || (state == S_DONE) || (state == S_ERR)) && start) begin
        sort_cycles <= '0;
      end
    end
  end
`else
  assign sort_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_kd_tree_ctrl.sv
// tb_kd_tree_ctrl: directed test of the kd-tree build sequencer with NUM_CENTERS=4, TIMEOUT=16.
module tb_kd_tree_ctrl;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned CMD_W  = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [31:0] sort_cycles;

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0] centers [4];

  kd_tree_ctrl_if #(.DATA_W(DATA_W), .CMD_W(CMD_W)) bus ();

  kd_tree_ctrl #(
    .DATA_W(DATA_W), .CMD_W(CMD_W), .NUM_CENTERS(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus.master),
    .busy(busy), .done(done), .error(error),
    .err_code(err_code), .sort_cycles(sort_cycles)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // start -> RST -> rst_done -> FILL
  task automatic enter_fill();
    start = 1'b1;
    step();
    start = 1'b0;
    bus.cmd_from_root = 5'h1e;
    step();
    bus.cmd_from_root = 5'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] exp_perf;
    centers[0] = 24'h112233;
    centers[1] = 24'h445566;
    centers[2] = 24'h778899;
    centers[3] = 24'hAABBCC;
`ifdef KD_TREE_CTRL_PERF_EN
    exp_perf = 32'd10;
`else
    exp_perf = 32'd0;
`endif

    // Reset state
    reset = 1'b1; start = 1'b0;
    bus.center_valid = 1'b0; bus.center_data = '0; bus.cmd_from_root = 5'h00;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_cmd", 32'(bus.cmd_to_root), 32'h00);
    check("rst_data", 32'(bus.data_to_root), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_errcode", 32'(err_code), 32'd0);
    check("rst_ready", 32'(bus.center_ready), 32'd0);
    check("rst_sortcyc", sort_cycles, 32'd0);

    // Start: rst command repeats until rst_done
    start = 1'b1;
    step();
    start = 1'b0;
    check("rst_cmd1", 32'(bus.cmd_to_root), 32'h1f);
    check("rst_busy1", 32'(busy), 32'd1);
    step();
    check("rst_cmd2", 32'(bus.cmd_to_root), 32'h1f);
    bus.cmd_from_root = 5'h1e;
    step();
    bus.cmd_from_root = 5'h00;
    check("fill_entry_cmd", 32'(bus.cmd_to_root), 32'h00);

    // Back-to-back fill of four centers
    for (int i = 0; i < 4; i++) begin
      bus.center_valid = 1'b1;
      bus.center_data  = centers[i];
      #1;
      check($sformatf("fill_ready%0d", i), 32'(bus.center_ready), 32'd1);
      step();
      check($sformatf("fill_cmd%0d", i), 32'(bus.cmd_to_root), 32'h01);
      check($sformatf("fill_data%0d", i), 32'(bus.data_to_root), 32'(centers[i]));
    end
    check("fill_ready_full", 32'(bus.center_ready), 32'd0);
    step();
    check("fill_full_cmd", 32'(bus.cmd_to_root), 32'h00);
    check("fill_full_data_hold", 32'(bus.data_to_root), 32'hAABBCC);
    bus.center_valid = 1'b0;
    bus.cmd_from_root = 5'h05;
    step();
    bus.cmd_from_root = 5'h00;
    check("sortgo_cmd", 32'(bus.cmd_to_root), 32'h09);
    check("sortgo_data", 32'(bus.data_to_root), 32'h0);

    // valid_sort ten cycles after start_sorting
    for (int i = 0; i < 9; i++) step();
    check("sortwait_cmd", 32'(bus.cmd_to_root), 32'h00);
    check("sortwait_busy", 32'(busy), 32'd1);
    step();
    bus.cmd_from_root = 5'h0f;
    step();
    bus.cmd_from_root = 5'h00;
    check("done_done", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_sortcyc", sort_cycles, exp_perf);

    // Backpressure and early fill done
    enter_fill();
    for (int i = 0; i < 2; i++) begin
      bus.center_valid = 1'b1;
      bus.center_data  = centers[i];
      step();
      check($sformatf("bp_cmd_acc%0d", i), 32'(bus.cmd_to_root), 32'h01);
      check($sformatf("bp_data_acc%0d", i), 32'(bus.data_to_root), 32'(centers[i]));
      bus.center_valid = 1'b0;
      step();
      check($sformatf("bp_cmd_idle%0d", i), 32'(bus.cmd_to_root), 32'h00);
      check($sformatf("bp_data_hold%0d", i), 32'(bus.data_to_root), 32'(centers[i]));
    end
    bus.center_valid = 1'b1;
    bus.center_data  = centers[2];
    bus.cmd_from_root = 5'h05;
    #1;
    check("early_ready", 32'(bus.center_ready), 32'd0);
    step();
    bus.center_valid = 1'b0;
    check("early_cmd", 32'(bus.cmd_to_root), 32'h09);
    check("early_data", 32'(bus.data_to_root), 32'h0);
    // valid_sort already during SORT_GO
    bus.cmd_from_root = 5'h0f;
    step();
    bus.cmd_from_root = 5'h00;
    check("fast_done", 32'(done), 32'd1);
    check("fast_sortcyc", sort_cycles, 32'd0);

    // Reset timeout
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("rtmo_not_yet", 32'(error), 32'd0);
    step();
    check("rtmo_error", 32'(error), 32'd1);
    check("rtmo_code", 32'(err_code), 32'd1);
    check("rtmo_busy", 32'(busy), 32'd0);
    check("rtmo_cmd", 32'(bus.cmd_to_root), 32'h00);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_error", 32'(error), 32'd0);
    check("restart_code", 32'(err_code), 32'd0);
    check("restart_cmd", 32'(bus.cmd_to_root), 32'h1f);

    // Reset in the middle of a fill, then refill from the first center
    bus.cmd_from_root = 5'h1e;
    step();
    bus.cmd_from_root = 5'h00;
    for (int i = 0; i < 2; i++) begin
      bus.center_valid = 1'b1;
      bus.center_data  = centers[i];
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("midrst_cmd", 32'(bus.cmd_to_root), 32'h00);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(bus.center_ready), 32'd0);
    bus.center_valid = 1'b0;
    enter_fill();
    for (int i = 0; i < 4; i++) begin
      bus.center_valid = 1'b1;
      bus.center_data  = centers[i];
      #1;
      check($sformatf("refill_ready%0d", i), 32'(bus.center_ready), 32'd1);
      step();
      check($sformatf("refill_data%0d", i), 32'(bus.data_to_root), 32'(centers[i]));
    end
    check("refill_ready_full", 32'(bus.center_ready), 32'd0);
    bus.center_valid = 1'b0;

    // Fill timeout: quota reached, no fill done from the root
    for (int i = 0; i < 15; i++) step();
    check("ftmo_not_yet", 32'(error), 32'd0);
    step();
    check("ftmo_error", 32'(error), 32'd1);
    check("ftmo_code", 32'(err_code), 32'd2);

    // Sort timeout
    enter_fill();
    bus.cmd_from_root = 5'h05;
    step();
    bus.cmd_from_root = 5'h00;
    n = 0;
    while (error !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("stmo_cycles", 32'(n), 32'd17);
    check("stmo_code", 32'(err_code), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
